cipher_writeback: RTL

CIPHER_WRITEBACK -- requirements
Module: cipher_writeback

---
 rtl/cipher_writeback.sv | 110 +++++++++++
 1 files changed

// File: rtl/cipher_writeback.sv
// Cipher result writeback: streams a captured AES result into SRAM byte by byte (encrypt)
// or compares it against a SHA3 digest (decrypt), then holds a sticky done.
module cipher_writeback #(
   parameter int SRAM_DATA_BW = 8,
   parameter int SRAM_ADDR_BW = 5,
   parameter int SHA_DATA_BW  = 256,
   parameter int AES_TXT_BW   = 128
) (
   input  logic                    clk,
   input  logic                    srst_n,
   input  logic                    enable,
   input  logic                    mode,
   input  logic                    aes_done,
   input  logic [AES_TXT_BW-1:0]   aes_o_msb,
   input  logic [AES_TXT_BW-1:0]   aes_o_lsb,
   input  logic [SHA_DATA_BW-1:0]  sha3_o,
   input  logic                    sha3_done,
   output logic [SRAM_ADDR_BW-1:0] cph_sram_addr,
   output logic [SRAM_DATA_BW-1:0] cph_sram_wdata,
   output logic                    cph_sram_wen_n,
   output logic                    done,
   output logic                    auth_pass,
   output logic [1:0]              fsm_state
);

   localparam int NUM_BEATS = SHA_DATA_BW / SRAM_DATA_BW;
   localparam logic [SRAM_ADDR_BW-1:0] LAST_ADDR = SRAM_ADDR_BW'(NUM_BEATS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [SHA_DATA_BW-1:0] buffer;
   logic [SHA_DATA_BW-1:0] aes_word;
   logic                   capture;
   logic                   last_beat;

   assign aes_word  = {aes_o_msb, aes_o_lsb};
   assign capture   = (state == ST_IDLE) && enable && aes_done;
   assign last_beat = (state == ST_WRITE) && (cph_sram_addr == LAST_ADDR);
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (!srst_n) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (capture) state_nxt = mode ? ST_CHECK : ST_WRITE;
         ST_WRITE: if (last_beat) state_nxt = ST_DONE;
         ST_CHECK: if (sha3_done) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_DONE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Beat 0 is launched straight from the inputs on the capture edge so it is on the
   // bus in the very next cycle; later beats come from the shifting buffer.
   always_ff @(posedge clk) begin
      if (!srst_n) begin
         buffer         <= '0;
         cph_sram_addr  <= '0;
         cph_sram_wdata <= '0;
         cph_sram_wen_n <= 1'b1;
         done           <= 1'b0;
         auth_pass      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (capture) begin
                  buffer <= aes_word;
                  if (!mode) begin
                     cph_sram_addr  <= '0;
                     cph_sram_wdata <= aes_word[SHA_DATA_BW-1 -: SRAM_DATA_BW];
                     cph_sram_wen_n <= 1'b0;
                  end
               end
            end
            ST_WRITE: begin
               if (last_beat) begin
                  cph_sram_addr  <= '0;
                  cph_sram_wdata <= '0;
                  cph_sram_wen_n <= 1'b1;
                  done           <= 1'b1;
               end else begin
                  // buffer still holds the current beat in its top byte
                  cph_sram_addr  <= cph_sram_addr + 1'b1;
                  cph_sram_wdata <= buffer[SHA_DATA_BW-SRAM_DATA_BW-1 -: SRAM_DATA_BW];
                  buffer         <= buffer << SRAM_DATA_BW;
               end
            end
            ST_CHECK: begin
               if (sha3_done) begin
                  auth_pass <= (buffer == sha3_o);
                  done      <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
